// File: rtl/i2c_cfg_target_if.sv
// rtl/i2c_cfg_target_if.sv - I2C pin bundle between the bus controller side and the config target.
interface i2c_cfg_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport slave  (input scl_in, input sda_in, output sda_oe);
    modport master (output scl_in, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_cfg_target.sv
// rtl/i2c_cfg_target.sv - I2C target owning the PWM configuration register file.
// Optional read path is enabled by defining I2C_CFG_READBACK_EN.
module i2c_cfg_target #(
    parameter logic [6:0] ADDR     = 7'h42,
    parameter int         NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_cfg_target_if.slave       i2c,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_strobe,
    output logic                  busy
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_WAIT
`ifdef I2C_CFG_READBACK_EN
        , S_RDATA, S_RDATA_ACK
`endif
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_p_q;
    logic sda_s1_q, sda_s2_q, sda_p_q;

    state_t                state_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic                  byte_done_q;
    logic [PW-1:0]         ptr_q;
    logic [NUM_REGS*8-1:0] regs_q;
    logic                  sda_oe_q;
    logic                  busy_q;
    logic                  wr_strobe_q;

    logic          scl_rise, scl_fall, start_det, stop_det, addr_ok;
    logic [7:0]    byte_d;
    logic [PW-1:0] ptr_d;

    // Sync flops reset to the idle-bus level so reset release cannot fake a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_p_q <= 1'b1;
            sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_p_q <= 1'b1;
        end else begin
            scl_s1_q <= i2c.scl_in; scl_s2_q <= scl_s1_q; scl_p_q <= scl_s2_q;
            sda_s1_q <= i2c.sda_in; sda_s2_q <= sda_s1_q; sda_p_q <= sda_s2_q;
        end
    end

    // START/STOP qualify on the previous SCL sample so they win over a coincident SCL edge.
    assign scl_rise  =  scl_s2_q & ~scl_p_q;
    assign scl_fall  = ~scl_s2_q &  scl_p_q;
    assign start_det =  scl_p_q &  sda_p_q & ~sda_s2_q;
    assign stop_det  =  scl_p_q & ~sda_p_q &  sda_s2_q;
    assign byte_d    = {shift_q[6:0], sda_s2_q};
    assign ptr_d     = ptr_q + PW'(1);

`ifdef I2C_CFG_READBACK_EN
    logic       rw_q;
    logic [7:0] cur_reg, next_reg;
    assign cur_reg  = regs_q[{ptr_q, 3'b000} +: 8];
    assign next_reg = regs_q[{ptr_d, 3'b000} +: 8];
    assign addr_ok  = (shift_q[7:1] == ADDR);
`else
    assign addr_ok  = (shift_q[7:1] == ADDR) && !shift_q[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            ptr_q       <= '0;
            regs_q      <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
`ifdef I2C_CFG_READBACK_EN
            rw_q        <= 1'b0;
`endif
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_det) begin
                state_q     <= S_ADDR;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
            end else if (stop_det) begin
                state_q     <= S_IDLE;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: begin
                        shift_q   <= byte_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
                    end
`ifdef I2C_CFG_READBACK_EN
                    S_RDATA: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
                    end
                    S_RDATA_ACK: begin
                        if (sda_s2_q) begin
                            state_q <= S_WAIT;
                            busy_q  <= 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    S_ADDR: begin
                        if (byte_done_q) begin
                            byte_done_q <= 1'b0;
                            if (addr_ok) begin
                                state_q  <= S_ADDR_ACK;
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
`ifdef I2C_CFG_READBACK_EN
                                rw_q     <= shift_q[0];
`endif
                            end else begin
                                state_q <= S_WAIT;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        bit_cnt_q <= 3'd0;
`ifdef I2C_CFG_READBACK_EN
                        if (rw_q) begin
                            state_q  <= S_RDATA;
                            shift_q  <= cur_reg;
                            sda_oe_q <= ~cur_reg[7];
                        end else begin
                            state_q  <= S_PTR;
                            sda_oe_q <= 1'b0;
                        end
`else
                        state_q  <= S_PTR;
                        sda_oe_q <= 1'b0;
`endif
                    end
                    S_PTR: begin
                        if (byte_done_q) begin
                            byte_done_q <= 1'b0;
                            ptr_q       <= shift_q[PW-1:0];
                            state_q     <= S_PTR_ACK;
                            sda_oe_q    <= 1'b1;
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        state_q  <= S_WDATA;
                        sda_oe_q <= 1'b0;
                    end
                    S_WDATA: begin
                        if (byte_done_q) begin
                            byte_done_q                    <= 1'b0;
                            regs_q[{ptr_q, 3'b000} +: 8]   <= shift_q;
                            wr_strobe_q                    <= 1'b1;
                            ptr_q                          <= ptr_d;
                            state_q                        <= S_WDATA_ACK;
                            sda_oe_q                       <= 1'b1;
                        end
                    end
`ifdef I2C_CFG_READBACK_EN
                    S_RDATA: begin
                        if (byte_done_q) begin
                            byte_done_q <= 1'b0;
                            sda_oe_q    <= 1'b0;
                            state_q     <= S_RDATA_ACK;
                        end else begin
                            shift_q  <= {shift_q[6:0], 1'b0};
                            sda_oe_q <= ~shift_q[6];
                        end
                    end
                    // Reaching this fall still in RDATA_ACK means the controller ACKed.
                    S_RDATA_ACK: begin
                        ptr_q     <= ptr_d;
                        shift_q   <= next_reg;
                        sda_oe_q  <= ~next_reg[7];
                        bit_cnt_q <= 3'd0;
                        state_q   <= S_RDATA;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign i2c.sda_oe = sda_oe_q;
    assign regs       = regs_q;
    assign wr_strobe  = wr_strobe_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_i2c_cfg_target.sv
// tb/tb_i2c_cfg_target.sv - Directed self-checking bench for i2c_cfg_target.
module tb_i2c_cfg_target;
    localparam int Q = 4;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_cfg_target_if bus();
    logic        sda_ctl;
    logic [63:0] regs;
    logic        wr_strobe, busy;

    assign bus.sda_in = sda_ctl & ~bus.sda_oe;

    i2c_cfg_target #(.ADDR(7'h42), .NUM_REGS(8)) dut (
        .clk(clk), .rst(rst), .i2c(bus.slave),
        .regs(regs), .wr_strobe(wr_strobe), .busy(busy)
    );

    int checks = 0, failures = 0;
    int strobe_cnt = 0, strobe_wide = 0, oe_cycles = 0, busy_cycles = 0;
    logic strobe_prev = 1'b0;
    logic [7:0] exp_regs [8];

    always @(posedge clk) begin
        if (wr_strobe) strobe_cnt++;
        if (wr_strobe && strobe_prev) strobe_wide++;
        strobe_prev = wr_strobe;
        if (bus.sda_oe) oe_cycles++;
        if (busy) busy_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1; tick(Q);
        bus.scl_in = 1'b1; tick(H);
        sda_ctl = 1'b0; tick(H);
        bus.scl_in = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; tick(Q);
        bus.scl_in = 1'b1; tick(H);
        sda_ctl = 1'b1; tick(4);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_ctl = b[i]; tick(Q);
            bus.scl_in = 1'b1; tick(H);
            bus.scl_in = 1'b0; tick(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_n);
        send_bits(b, 8);
        sda_ctl = 1'b1; tick(Q);
        bus.scl_in = 1'b1; tick(H / 2);
        ack_n = bus.sda_in; tick(H / 2);
        bus.scl_in = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        sda_ctl = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            bus.scl_in = 1'b1; tick(H / 2);
            b[i] = bus.sda_in; tick(H / 2);
            bus.scl_in = 1'b0; tick(Q);
        end
        sda_ctl = nack; tick(Q);
        bus.scl_in = 1'b1; tick(H);
        bus.scl_in = 1'b0; tick(Q);
        sda_ctl = 1'b1;
    endtask

    task automatic test_reset();
        int s0, o0;
        rst = 1'b1; tick(3);
        checks++; if (bus.sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %0b expected 0", bus.sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe: got %0b expected 0", wr_strobe); end
        checks++; if (regs !== 64'h0) begin failures++; $display("FAIL reset_regs: got %0h expected 0", regs); end
        rst = 1'b0;
        s0 = strobe_cnt; o0 = oe_cycles;
        tick(100);
        checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL idle_strobe: got %0d pulses expected 0", strobe_cnt - s0); end
        checks++; if (oe_cycles !== o0) begin failures++; $display("FAIL idle_sda_oe: got %0d low cycles expected 0", oe_cycles - o0); end
        checks++; if (busy !== 1'b0 || regs !== 64'h0) begin failures++; $display("FAIL idle_state: got busy=%0b regs=%0h expected 0/0", busy, regs); end
    endtask

    task automatic test_write();
        logic [7:0] bytes [4];
        logic ack_n;
        int s0;
        bytes[0] = 8'h84; bytes[1] = 8'h02; bytes[2] = 8'hA5; bytes[3] = 8'h3C;
        s0 = strobe_cnt;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], ack_n);
            checks++; if (ack_n !== 1'b0) begin failures++; $display("FAIL write_ack%0d: got %0b expected 0", i, ack_n); end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %0b expected 1", busy); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after_stop: got %0b expected 0", busy); end
        exp_regs[2] = 8'hA5; exp_regs[3] = 8'h3C;
        checks++; if (regs[23:16] !== 8'hA5) begin failures++; $display("FAIL write_reg2: got %0h expected a5", regs[23:16]); end
        checks++; if (regs[31:24] !== 8'h3C) begin failures++; $display("FAIL write_reg3: got %0h expected 3c", regs[31:24]); end
        checks++; if (strobe_cnt - s0 !== 2) begin failures++; $display("FAIL write_strobes: got %0d expected 2", strobe_cnt - s0); end
        checks++; if (strobe_wide !== 0) begin failures++; $display("FAIL write_strobe_width: got %0d wide cycles expected 0", strobe_wide); end
    endtask

    task automatic test_wrap();
        logic ack_n;
        i2c_start();
        write_byte(8'h84, ack_n);
        write_byte(8'h07, ack_n);
        write_byte(8'h11, ack_n);
        write_byte(8'h22, ack_n);
        i2c_stop();
        exp_regs[7] = 8'h11; exp_regs[0] = 8'h22;
        checks++; if (regs[63:56] !== 8'h11) begin failures++; $display("FAIL wrap_reg7: got %0h expected 11", regs[63:56]); end
        checks++; if (regs[7:0] !== 8'h22) begin failures++; $display("FAIL wrap_reg0: got %0h expected 22", regs[7:0]); end
        checks++; if (regs[23:16] !== 8'hA5) begin failures++; $display("FAIL wrap_reg2_kept: got %0h expected a5", regs[23:16]); end
    endtask

    task automatic test_wrong_addr();
        logic ack_n;
        int o0, b0;
        o0 = oe_cycles; b0 = busy_cycles;
        i2c_start();
        write_byte(8'h86, ack_n);
        checks++; if (ack_n !== 1'b1) begin failures++; $display("FAIL wrong_addr_nack: got %0b expected 1", ack_n); end
        write_byte(8'h00, ack_n);
        write_byte(8'hFF, ack_n);
        checks++; if (ack_n !== 1'b1) begin failures++; $display("FAIL wrong_addr_data_nack: got %0b expected 1", ack_n); end
        i2c_stop();
        checks++; if (oe_cycles !== o0) begin failures++; $display("FAIL wrong_addr_sda: got %0d low cycles expected 0", oe_cycles - o0); end
        checks++; if (busy_cycles !== b0) begin failures++; $display("FAIL wrong_addr_busy: got %0d busy cycles expected 0", busy_cycles - b0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (regs[i*8 +: 8] !== exp_regs[i]) begin failures++; $display("FAIL wrong_addr_reg%0d: got %0h expected %0h", i, regs[i*8 +: 8], exp_regs[i]); end
        end
    endtask

    task automatic test_readback();
        logic ack_n;
        logic [7:0] rd;
        i2c_start();
        write_byte(8'h84, ack_n);
        write_byte(8'h02, ack_n);
        i2c_start();
        write_byte(8'h85, ack_n);
`ifdef I2C_CFG_READBACK_EN
        checks++; if (ack_n !== 1'b0) begin failures++; $display("FAIL read_addr_ack: got %0b expected 0", ack_n); end
        read_byte(1'b0, rd);
        checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL read_byte0: got %0h expected a5", rd); end
        read_byte(1'b1, rd);
        checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL read_byte1: got %0h expected 3c", rd); end
        checks++; if (bus.sda_oe !== 1'b0) begin failures++; $display("FAIL read_release: got %0b expected 0", bus.sda_oe); end
`else
        rd = 8'h00;
        checks++; if (ack_n !== 1'b1) begin failures++; $display("FAIL read_addr_nack: got %0b expected 1", ack_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy: got %0b expected 0", busy); end
        checks++; if (bus.sda_oe !== 1'b0 || rd !== 8'h00) begin failures++; $display("FAIL read_sda_oe: got %0b expected 0", bus.sda_oe); end
`endif
        i2c_stop();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_after_stop: got %0b expected 0", busy); end
    endtask

    task automatic test_stop_mid();
        logic ack_n;
        int s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h84, ack_n);
        write_byte(8'h05, ack_n);
        send_bits(8'hEE, 4);
        i2c_stop();
        checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL stop_mid_strobe: got %0d pulses expected 0", strobe_cnt - s0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (regs[i*8 +: 8] !== exp_regs[i]) begin failures++; $display("FAIL stop_mid_reg%0d: got %0h expected %0h", i, regs[i*8 +: 8], exp_regs[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic ack_n;
        i2c_start();
        write_byte(8'h84, ack_n);
        write_byte(8'h06, ack_n);
        send_bits(8'h77, 4);
        rst = 1'b1; tick(2);
        checks++; if (regs !== 64'h0) begin failures++; $display("FAIL rst_mid_regs: got %0h expected 0", regs); end
        checks++; if (busy !== 1'b0 || bus.sda_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs: got busy=%0b sda_oe=%0b expected 0/0", busy, bus.sda_oe); end
        rst = 1'b0; sda_ctl = 1'b1; tick(8);
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        i2c_start();
        write_byte(8'h84, ack_n);
        write_byte(8'h01, ack_n);
        write_byte(8'h5A, ack_n);
        checks++; if (ack_n !== 1'b0) begin failures++; $display("FAIL rst_mid_recover_ack: got %0b expected 0", ack_n); end
        i2c_stop();
        exp_regs[1] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            checks++; if (regs[i*8 +: 8] !== exp_regs[i]) begin failures++; $display("FAIL rst_mid_reg%0d: got %0h expected %0h", i, regs[i*8 +: 8], exp_regs[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        bus.scl_in = 1'b1;
        sda_ctl    = 1'b1;
        rst        = 1'b0;
        tick(1);
        test_reset();
        test_write();
        test_wrap();
        test_wrong_addr();
        test_readback();
        test_stop_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_cfg_target.md
# i2c_cfg_target

I2C target (slave) that owns the LED PWM configuration register file and lets an external I2C controller write and read it. It sits between the uio pins and the PWM channel datapath. It decodes SCL/SDA, drives SDA open-drain for ACK and read data, and presents all channel registers as a flat bus to the PWM generators. SCL is never driven, so there is no clock stretching.

## Interface
- `ADDR`, 7'h42, 7-bit target address.
- `NUM_REGS`, 8, number of 8-bit registers; power of two, 2..16.
- `clk`  input  1  system clock; must be ≥ 8× SCL frequency.
- `rst`  input  1  asynchronous, active-high reset.
- `scl_in`  input  1  raw SCL pin (uio_in[2]).
- `sda_in`  input  1  raw SDA pin (uio_in[1]).
- `sda_oe`  output  1  1 = pull SDA low; drives uio_oe[1]. uio_out[1] is tied 0 externally.
- `regs`  output  NUM_REGS*8  register file; reg i occupies bits [8i+7:8i].
- `wr_strobe`  output  1  one-cycle pulse when any register is committed.
- `busy`  output  1  high from a matching address ACK until STOP or NACK.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer. Edge detection runs on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Both are detected in every state.
  - START (including repeated START) → ADDR. STOP → IDLE, sda_oe=0, busy=0.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- Bits are sampled on the SCL rising edge, MSB first, using a 3-bit counter.
- ADDR: after 8 bits, if addr[7:1]==ADDR, go to ADDR_ACK and assert ACK. Otherwise go to WAIT with no ACK.
- Write path (R/W=0): ADDR_ACK → PTR. The received byte loads the pointer; bits above clog2(NUM_REGS) are ignored. PTR_ACK (ACK) → WDATA.
- WDATA: after 8 bits, regs[ptr] ← byte and wr_strobe pulses. Both happen in the same cycle sda_oe rises for ACK. Then ptr ← ptr+1 mod NUM_REGS, and the state goes WDATA_ACK → WDATA.
- Read path (R/W=1): ADDR_ACK → RDATA. Shift out regs[ptr] by holding sda_oe = ~bit.
  - The shift register loads on the SCL fall that ends the ACK bit.
  - After 8 bits, release SDA and sample the controller's ACK in RDATA_ACK.
  - ACK (0): ptr+1 mod NUM_REGS, back to RDATA.
  - NACK (1): WAIT.
- WAIT: sda_oe=0, ignore traffic until START or STOP.
- The pointer persists across transactions. It is reset only by `rst`.
- sda_oe changes only on a detected SCL falling edge, or on START/STOP/reset.
  - ACK: assert on the SCL fall after bit 8, release on the next SCL fall.

## Timing
- Reset (async assert, sync to clk on deassert): state=IDLE, sda_oe=0, busy=0, wr_strobe=0, regs all 0, ptr=0, bit counter=0.
- Pin-to-action latency: 3 clk (2 sync + 1 edge detect). sda_oe updates 3 clk after the SCL pin falls. This meets hold time because it is < SCL low time at ≥ 8× oversampling.
- wr_strobe is exactly 1 clk wide, once per data byte.
- START and an SCL edge in the same cycle: START wins and the bit counter clears.
- STOP mid-byte: the partial byte is discarded and no register changes.
- Reset mid-transaction: immediate IDLE. Registers return to 0.
- Pointer wrap: ptr=NUM_REGS-1, then the next byte lands in reg 0.

## Configuration
- `I2C_CFG_READBACK_EN` defined: the read path (RDATA, RDATA_ACK) exists as described.
- Not defined: the read states are removed. An address byte matching ADDR with R/W=1 is NACKed (sda_oe stays 0) → WAIT. busy stays 0.

## Test plan
- Reset then idle bus (SCL=SDA=1, 100 clk) → sda_oe=0, regs=0, busy=0, wr_strobe never pulses.
- Write S,0x84,0x02,0xA5,0x3C,P → ACK on all 4 bytes; regs[2]=0xA5, regs[3]=0x3C; two wr_strobe pulses; busy falls within 4 clk after STOP.
- Write S,0x84,0x07,0x11,0x22,P (NUM_REGS=8) → regs[7]=0x11, regs[0]=0x22 (wrap).
- Wrong address S,0x86,0x00,0xFF,P → SDA never pulled low, regs unchanged, busy=0.
- With I2C_CFG_READBACK_EN: S,0x84,0x02,Sr,0x85, read 2 bytes with ACK then NACK, P → SDA shows 0xA5 then 0x3C; SDA released after the NACK. Without the macro: 0x85 is NACKed.
- STOP after 4 bits of a data byte, and separately rst pulsed mid-byte → no register change from STOP; all regs 0 after rst; the next full transaction works normally.
